// File: rtl/rtc_write_seq.sv
// rtc_write_seq: snapshots time/date/timer BCD fields and serialises them
// as addr/data byte writes on a four-phase req/ack bus, then an XFER commit.
// Ports: clk, rst_n, wr_start, grp_mask, nine BCD fields, ampm, bus_req,
// bus_addr, bus_data, bus_ack, busy, done, err.
// Optional macro RTC_AMPM_EN: hora byte is written as {ampm, hora[6:0]}.
module rtc_write_seq #(
  parameter logic [7:0] ADDR_SEG    = 8'h21,
  parameter logic [7:0] ADDR_MIN    = 8'h22,
  parameter logic [7:0] ADDR_HORA   = 8'h23,
  parameter logic [7:0] ADDR_DIA    = 8'h24,
  parameter logic [7:0] ADDR_MES    = 8'h25,
  parameter logic [7:0] ADDR_YEAR   = 8'h26,
  parameter logic [7:0] ADDR_SEGCR  = 8'h41,
  parameter logic [7:0] ADDR_MINCR  = 8'h42,
  parameter logic [7:0] ADDR_HORACR = 8'h43,
  parameter logic [7:0] ADDR_XFER   = 8'hF2,
  parameter int         TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_start,
  input  logic [2:0] grp_mask,
  input  logic [7:0] hora,
  input  logic [7:0] min,
  input  logic [7:0] seg,
  input  logic [7:0] dia,
  input  logic [7:0] mes,
  input  logic [7:0] year,
  input  logic [7:0] horacr,
  input  logic [7:0] mincr,
  input  logic [7:0] segcr,
  input  logic       ampm,
  output logic       bus_req,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_data,
  input  logic       bus_ack,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [3:0] NONE = 4'd10;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_ACK, WAIT_REL, DONE
  } state_t;

  state_t state_q, state_d;
  logic [3:0] slot_q, slot_d;
  logic [2:0] mask_q, mask_d;
  logic [8:0][7:0] snap_q, snap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic req_q, req_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic [7:0] hora_byte;
  logic [7:0] slot_addr;
  logic [7:0] slot_data;
  logic [3:0] nxt;

`ifdef RTC_AMPM_EN
  logic ampm_q, ampm_d;
  logic unused_hora7;
  assign unused_hora7 = snap_q[2][7];
  assign hora_byte = {ampm_q, snap_q[2][6:0]};
`else
  logic unused_ampm;
  assign unused_ampm = ampm;
  assign hora_byte = snap_q[2];
`endif

  // Slots 0-2 time, 3-5 date, 6-8 timer, 9 XFER (time or date present).
  function automatic logic slot_en(input logic [3:0] s,
                                   input logic [2:0] m);
    logic en;
    if (s <= 4'd2)      en = m[0];
    else if (s <= 4'd5) en = m[1];
    else if (s <= 4'd8) en = m[2];
    else if (s == 4'd9) en = m[0] | m[1];
    else                en = 1'b0;
    return en;
  endfunction

  // First enabled slot at or after 'from', NONE if the list is exhausted.
  function automatic logic [3:0] next_slot(input logic [3:0] from,
                                           input logic [2:0] m);
    logic [3:0] r;
    r = NONE;
    for (int i = 9; i >= 0; i--)
      if (4'(i) >= from && slot_en(4'(i), m)) r = 4'(i);
    return r;
  endfunction

  always_comb begin
    slot_addr = 8'h00;
    slot_data = 8'h00;
    case (slot_q)
      4'd0: begin slot_addr = ADDR_SEG;    slot_data = snap_q[0]; end
      4'd1: begin slot_addr = ADDR_MIN;    slot_data = snap_q[1]; end
      4'd2: begin slot_addr = ADDR_HORA;   slot_data = hora_byte; end
      4'd3: begin slot_addr = ADDR_DIA;    slot_data = snap_q[3]; end
      4'd4: begin slot_addr = ADDR_MES;    slot_data = snap_q[4]; end
      4'd5: begin slot_addr = ADDR_YEAR;   slot_data = snap_q[5]; end
      4'd6: begin slot_addr = ADDR_SEGCR;  slot_data = snap_q[6]; end
      4'd7: begin slot_addr = ADDR_MINCR;  slot_data = snap_q[7]; end
      4'd8: begin slot_addr = ADDR_HORACR; slot_data = snap_q[8]; end
      4'd9: begin slot_addr = ADDR_XFER;   slot_data = 8'h00;     end
      default: ;
    endcase
  end

  assign nxt = next_slot(slot_q + 4'd1, mask_q);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    mask_d  = mask_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef RTC_AMPM_EN
    ampm_d  = ampm_q;
`endif
    unique case (state_q)
      IDLE: if (wr_start) begin
        snap_d = {horacr, mincr, segcr, year, mes, dia, hora, min, seg};
`ifdef RTC_AMPM_EN
        ampm_d = ampm;
`endif
        mask_d = grp_mask;
        err_d  = 1'b0;
        busy_d = 1'b1;
        slot_d = next_slot(4'd0, grp_mask);
        if (grp_mask == 3'b000) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        addr_d  = slot_addr;
        data_d  = slot_data;
        req_d   = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus_ack) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_REL;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_REL: begin
        if (!bus_ack) begin
          if (nxt == NONE) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            slot_d  = nxt;
            state_d = ISSUE;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      mask_q  <= '0;
      snap_q  <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef RTC_AMPM_EN
      ampm_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      mask_q  <= mask_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef RTC_AMPM_EN
      ampm_q  <= ampm_d;
`endif
    end
  end

  assign bus_req  = req_q;
  assign bus_addr = addr_q;
  assign bus_data = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rtc_write_seq.sv
// tb_rtc_write_seq: directed bench for rtc_write_seq with a write
// scoreboard and a zero-latency (optionally silent) bus responder.
module tb_rtc_write_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_start;
  logic [2:0] grp_mask;
  logic [7:0] hora, min, seg, dia, mes, year;
  logic [7:0] horacr, mincr, segcr;
  logic       ampm;
  logic       bus_req;
  logic [7:0] bus_addr, bus_data;
  logic       bus_ack;
  logic       busy, done, err;
  logic       resp_en;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int rises = 0;
  logic prev_req = 1'b0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  assign bus_ack = resp_en & bus_req;

  rtc_write_seq #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_start(wr_start), .grp_mask(grp_mask),
    .hora(hora), .min(min), .seg(seg),
    .dia(dia), .mes(mes), .year(year),
    .horacr(horacr), .mincr(mincr), .segcr(segcr), .ampm(ampm),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_ack(bus_ack), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    sb.push_back({a, d});
  endtask

  task automatic start(input logic [2:0] m);
    grp_mask = m;
    wr_start = 1'b1;
    @(negedge clk);
    wr_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag,
                           output int cyc, output int busy_low);
    logic got;
    got = 1'b0;
    cyc = 0;
    busy_low = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cyc = i + 1;
      if (busy !== 1'b1) busy_low++;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
  endtask

  // Every bus_req rising edge is one write; match it against the queue.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (bus_req === 1'b1 && prev_req === 1'b0) begin
      rises++;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected observed=%0h expected=none",
               {bus_addr, bus_data});
      end
      if (sb.size() != 0)
        chk("sb_write", 32'({bus_addr, bus_data}), 32'(sb.pop_front()));
    end
    prev_req = bus_req;
  end

  initial begin
    int cyc, bl, d0, r0, hi;
    logic got;
    logic [7:0] hora_exp;
    rst_n = 1'b0; wr_start = 1'b0; grp_mask = 3'b000; resp_en = 1'b1;
    hora = 0; min = 0; seg = 0; dia = 0; mes = 0; year = 0;
    horacr = 0; mincr = 0; segcr = 0; ampm = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(bus_addr), 32'd0);
    chk("rst_data", 32'(bus_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Time only, immediate responder.
    seg = 8'h45; min = 8'h30; hora = 8'h12;
    push(8'h21, 8'h45); push(8'h22, 8'h30);
    push(8'h23, 8'h12); push(8'hF2, 8'h00);
    d0 = done_cnt;
    start(3'b001);
    chk("t1_req_latency", 32'(bus_req), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_req_rise", 32'(bus_req), 32'd1);
    chk("t1_first_addr", 32'(bus_addr), 32'h21);
    wait_done(100, "t1", cyc, bl);
    chk("t1_err", 32'(err), 32'd0);
    @(negedge clk);
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);
    chk("t1_busy_off", 32'(busy), 32'd0);

    // All groups: 10 writes at 3 cycles each.
    seg = 8'h59; min = 8'h58; hora = 8'h23;
    dia = 8'h05; mes = 8'h04; year = 8'h16;
    segcr = 8'h10; mincr = 8'h02; horacr = 8'h00;
    push(8'h21, 8'h59); push(8'h22, 8'h58); push(8'h23, 8'h23);
    push(8'h24, 8'h05); push(8'h25, 8'h04); push(8'h26, 8'h16);
    push(8'h41, 8'h10); push(8'h42, 8'h02); push(8'h43, 8'h00);
    push(8'hF2, 8'h00);
    d0 = done_cnt;
    start(3'b111);
    wait_done(200, "t2", cyc, bl);
    chk("t2_cycles", 32'(cyc), 32'd30);
    chk("t2_busy_low", 32'(bl), 32'd0);
    @(negedge clk);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);
    chk("t2_done_once", 32'(done_cnt - d0), 32'd1);

    // Timer only: no XFER.
    segcr = 8'h33; mincr = 8'h44; horacr = 8'h05;
    push(8'h41, 8'h33); push(8'h42, 8'h44); push(8'h43, 8'h05);
    r0 = rises;
    start(3'b100);
    wait_done(100, "t3", cyc, bl);
    @(negedge clk);
    chk("t3_writes", 32'(rises - r0), 32'd3);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Empty mask.
    r0 = rises; d0 = done_cnt;
    start(3'b000);
    chk("t4_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("t4_done_off", 32'(done), 32'd0);
    chk("t4_busy_off", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_no_req", 32'(rises - r0), 32'd0);
    chk("t4_done_once", 32'(done_cnt - d0), 32'd1);

    // Timeout with a silent responder; extra wr_start while busy.
    resp_en = 1'b0;
    seg = 8'h77;
    push(8'h21, 8'h77);
    r0 = rises;
    start(3'b001);
    hi = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 3) begin
        grp_mask = 3'b111;
        wr_start = 1'b1;
      end else begin
        wr_start = 1'b0;
      end
      if (bus_req === 1'b1) hi++;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    wr_start = 1'b0;
    chk("t5_done_seen", 32'(got), 32'd1);
    chk("t5_req_high_cycles", 32'(hi), 32'd8);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_req_off", 32'(bus_req), 32'd0);
    repeat (10) @(negedge clk);
    chk("t5_no_extra", 32'(rises - r0), 32'd1);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);
    chk("t5_err_sticky", 32'(err), 32'd1);
    chk("t5_busy_off", 32'(busy), 32'd0);

    // Follow-up clears err; also exercises the am/pm byte.
    resp_en = 1'b1;
    ampm = 1'b1; hora = 8'h11; seg = 8'h01; min = 8'h02;
`ifdef RTC_AMPM_EN
    hora_exp = 8'h91;
`else
    hora_exp = 8'h11;
`endif
    push(8'h21, 8'h01); push(8'h22, 8'h02);
    push(8'h23, hora_exp); push(8'hF2, 8'h00);
    start(3'b001);
    chk("t6_err_clear", 32'(err), 32'd0);
    wait_done(100, "t6", cyc, bl);
    @(negedge clk);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    // Async reset while waiting for ack.
    resp_en = 1'b0;
    seg = 8'h55;
    push(8'h21, 8'h55);
    start(3'b111);
    @(negedge clk);
    chk("t7_req_up", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_req", 32'(bus_req), 32'd0);
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_done", 32'(done), 32'd0);
    chk("t7_err", 32'(err), 32'd0);
    chk("t7_addr", 32'(bus_addr), 32'd0);
    chk("t7_data", 32'(bus_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b1;
    r0 = rises;
    repeat (3) @(negedge clk);
    chk("t7_idle_after", 32'(rises - r0), 32'd0);
    chk("t7_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
